// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue circular instruction FIFO between fetch2 and decode.
// Bubbles (zero instructions) are squeezed out on write so the queue only holds real work.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [31:0]      inst0_i,
    input  logic [31:0]      inst1_i,
    input  logic [31:0]      pc_i,
    input  logic             pred_0_i,
    input  logic             pred_1_i,
    input  logic             push_i,
    output logic             ready_o,
    input  logic             flush_i,
    output logic [31:0]      inst0_o,
    output logic [31:0]      inst1_o,
    output logic [31:0]      pc0_o,
    output logic [31:0]      pc1_o,
    output logic             pred0_o,
    output logic             pred1_o,
    output logic             valid0_o,
    output logic             valid1_o,
    input  logic [1:0]       pop_i,
    output logic [PTR_W:0]   count_o
);
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             pred_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr1, slot1;
    logic [PTR_W:0]   count, n_push, n_pop, pop_req;
    logic             v0, v1, accept;

    always_comb begin
        v0      = inst0_i != '0;
        v1      = inst1_i != '0;
        ready_o = count <= (PTR_W+1)'(DEPTH - 2);
        accept  = push_i && ready_o && !flush_i;
        n_push  = accept ? (PTR_W+1)'(v0) + (PTR_W+1)'(v1) : '0;
        pop_req = pop_i[1] ? (PTR_W+1)'(2) : (PTR_W+1)'(pop_i);
        n_pop   = pop_req > count ? count : pop_req;
        slot1   = v0 ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr1 = rd_ptr + PTR_W'(1);
    end

    // Flush drops everything buffered and overrides any same-cycle push or pop.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + n_pop[PTR_W-1:0];
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            count  <= count + n_push - n_pop;
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept && v0) begin
            inst_mem[wr_ptr] <= inst0_i;
            pc_mem[wr_ptr]   <= pc_i;
            pred_mem[wr_ptr] <= pred_0_i;
        end
        if (accept && v1) begin
            inst_mem[slot1] <= inst1_i;
            pc_mem[slot1]   <= pc_i + 32'd4;
            pred_mem[slot1] <= pred_1_i;
        end
    end

    always_comb begin
        valid0_o = count != '0;
        valid1_o = count >= (PTR_W+1)'(2);
        inst0_o  = valid0_o ? inst_mem[rd_ptr]  : '0;
        pc0_o    = valid0_o ? pc_mem[rd_ptr]    : '0;
        pred0_o  = valid0_o ? pred_mem[rd_ptr]  : 1'b0;
        inst1_o  = valid1_o ? inst_mem[rd_ptr1] : '0;
        pc1_o    = valid1_o ? pc_mem[rd_ptr1]   : '0;
        pred1_o  = valid1_o ? pred_mem[rd_ptr1] : 1'b0;
        count_o  = count;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven vectors plus a queue-based scoreboard for fetch_queue.
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    logic [31:0] inst0_i = '0, inst1_i = '0, pc_i = '0;
    logic pred_0_i = 1'b0, pred_1_i = 1'b0, push_i = 1'b0, flush_i = 1'b0;
    logic [1:0] pop_i = '0;
    logic ready_o, pred0_o, pred1_o, valid0_o, valid1_o;
    logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
    logic [PTR_W:0] count_o;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .inst0_i(inst0_i), .inst1_i(inst1_i),
        .pc_i(pc_i), .pred_0_i(pred_0_i), .pred_1_i(pred_1_i), .push_i(push_i),
        .ready_o(ready_o), .flush_i(flush_i), .inst0_o(inst0_o), .inst1_o(inst1_o),
        .pc0_o(pc0_o), .pc1_o(pc1_o), .pred0_o(pred0_o), .pred1_o(pred1_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o), .pop_i(pop_i), .count_o(count_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        push;
        logic [31:0] i0, i1, pc;
        logic        p0, p1;
        logic [1:0]  pop;
        logic        fl;
        logic [3:0]  cnt;
        logic [31:0] e_inst0, e_pc0, e_inst1;
        logic        e_pred0, e_v1, e_rdy;
    } vec_t;

    ent_t sb[$];
    vec_t vt[15];
    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cmp_sb(input string tag);
        ent_t e0, e1;
        int n;
        n = sb.size();
        e0 = '0;
        e1 = '0;
        if (n >= 1) e0 = sb[0];
        if (n >= 2) e1 = sb[1];
        chk({tag, "_sb_status"}, {valid0_o, valid1_o, ready_o, 28'(count_o)},
            {n >= 1, n >= 2, n <= DEPTH - 2, 28'(n)});
        chk({tag, "_sb_head0"}, {inst0_o, pc0_o, pred0_o}, e0);
        chk({tag, "_sb_head1"}, {inst1_o, pc1_o, pred1_o}, e1);
    endtask

    // Drive one cycle, advance the reference queue, then compare just after the edge.
    task automatic step(input logic push, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input logic p0, input logic p1,
                        input logic [1:0] pop, input logic fl, input string tag);
        int np;
        bit rdy;
        push_i = push; inst0_i = i0; inst1_i = i1; pc_i = pc;
        pred_0_i = p0; pred_1_i = p1; pop_i = pop; flush_i = fl;
        if (fl) sb.delete();
        else begin
            rdy = sb.size() <= DEPTH - 2;
            np = (pop == 2'd3) ? 2 : int'(pop);
            if (np > sb.size()) np = sb.size();
            repeat (np) void'(sb.pop_front());
            if (push && rdy) begin
                if (i0 != 0) sb.push_back('{i0, pc, p0});
                if (i1 != 0) sb.push_back('{i1, pc + 32'd4, p1});
            end
        end
        @(posedge clock_i);
        #1;
        push_i = 1'b0; pop_i = '0; flush_i = 1'b0;
        cmp_sb(tag);
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h13, 32'h00100093, 32'h100, 1'b0, 1'b0, 2'd0, 1'b0, 4'd2, 32'h13, 32'h100, 32'h00100093, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 32'h0, 32'h00A00113, 32'h200, 1'b0, 1'b1, 2'd2, 1'b0, 4'd1, 32'h00A00113, 32'h204, 32'h0, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 32'h0, 32'h0, 32'h280, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 32'h11111111, 32'h22222222, 32'h300, 1'b1, 1'b0, 2'd0, 1'b0, 4'd2, 32'h11111111, 32'h300, 32'h22222222, 1'b1, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 32'h33333333, 32'h44444444, 32'h308, 1'b0, 1'b0, 2'd0, 1'b0, 4'd4, 32'h11111111, 32'h300, 32'h22222222, 1'b1, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 32'h55555555, 32'h66666666, 32'h310, 1'b0, 1'b0, 2'd0, 1'b0, 4'd6, 32'h11111111, 32'h300, 32'h22222222, 1'b1, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 32'h77777777, 32'h0, 32'h318, 1'b0, 1'b0, 2'd0, 1'b0, 4'd7, 32'h11111111, 32'h300, 32'h22222222, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 32'h88888888, 32'h99999999, 32'h320, 1'b0, 1'b0, 2'd0, 1'b0, 4'd7, 32'h11111111, 32'h300, 32'h22222222, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h330, 1'b0, 1'b0, 2'd2, 1'b0, 4'd5, 32'h33333333, 32'h308, 32'h44444444, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd4, 32'h44444444, 32'h30C, 32'h55555555, 1'b0, 1'b1, 1'b1};
        vt[11] = '{1'b1, 32'hEEEEEEEE, 32'hFFFFFFFF, 32'h350, 1'b0, 1'b0, 2'd1, 1'b1, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h400, 1'b0, 1'b1, 2'd0, 1'b0, 4'd2, 32'h12345678, 32'h400, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b1};
        vt[13] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd1, 32'h9ABCDEF0, 32'h404, 32'h0, 1'b1, 1'b0, 1'b1};
        vt[14] = '{1'b1, 32'h0000AAAA, 32'h0000BBBB, 32'h500, 1'b0, 1'b0, 2'd1, 1'b0, 4'd2, 32'h0000AAAA, 32'h500, 32'h0000BBBB, 1'b0, 1'b1, 1'b1};

        #12;
        chk("reset_state", {valid0_o, valid1_o, ready_o, 28'(count_o)}, {1'b0, 1'b0, 1'b1, 28'd0});
        @(negedge clock_i) reset_i = 1'b1;
        #1;

        step(1'b1, 32'hA1, 32'hA2, 32'h10, 1'b0, 1'b0, 2'd0, 1'b0, "fill0");
        step(1'b1, 32'hA3, 32'hA4, 32'h18, 1'b0, 1'b0, 2'd0, 1'b0, "fill1");
        step(1'b1, 32'hA5, 32'h0, 32'h20, 1'b0, 1'b0, 2'd0, 1'b0, "fill2");
        chk("pre_reset_count", 96'(count_o), 96'd5);
        // Asynchronous reset in the middle of a cycle must clear state immediately.
        reset_i = 1'b0;
        sb.delete();
        #1;
        chk("async_reset", {valid0_o, valid1_o, ready_o, 28'(count_o), inst0_o},
            {1'b0, 1'b0, 1'b1, 28'd0, 32'd0});
        @(negedge clock_i) reset_i = 1'b1;
        #1;

        for (int i = 0; i < 15; i++) begin
            step(vt[i].push, vt[i].i0, vt[i].i1, vt[i].pc, vt[i].p0, vt[i].p1, vt[i].pop, vt[i].fl,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_out", i),
                {count_o, inst0_o, pc0_o, inst1_o, pred0_o, valid1_o, ready_o},
                {vt[i].cnt, vt[i].e_inst0, vt[i].e_pc0, vt[i].e_inst1, vt[i].e_pred0, vt[i].e_v1, vt[i].e_rdy});
        end

        // Steady state with an odd offset so pairs straddle the pointer wrap.
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "ss_flush");
        step(1'b1, 32'h1013, 32'h0, 32'h1000, 1'b0, 1'b0, 2'd0, 1'b0, "ss_single");
        step(1'b1, 32'h1017, 32'h101B, 32'h1004, 1'b1, 1'b0, 2'd0, 1'b0, "ss_pair");
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] p;
            logic [31:0] h;
            p = 32'h1004 + 32'(8 * k);
            h = 32'h1000 + 32'(8 * k);
            step(1'b1, p + 32'h13, p + 32'h17, p, k[0], 1'b0, 2'd2, 1'b0, $sformatf("ss%0d", k));
            chk($sformatf("ss%0d_out", k), {4'(count_o), pc0_o, inst0_o, pc1_o},
                {4'd3, h, h + 32'h13, h + 32'd4});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
